// File: rtl/tpu_if.sv
// Host-side bus of the tpu_v1 matrix-multiply accelerator: buffer access plus start/done.
interface tpu_if #(parameter int DW = 16);
    logic          tpu_start;
    logic [9:0]    write_addr;
    logic [9:0]    data_size;
    logic [DW-1:0] data_in;
    logic          write_en;
    logic [DW-1:0] data_out;
    logic          tpu_done;

    modport master (output tpu_start, write_addr, data_size, data_in, write_en,
                    input  data_out, tpu_done);
    modport slave  (input  tpu_start, write_addr, data_size, data_in, write_en,
                    output data_out, tpu_done);
endinterface

// File: rtl/tpu_v1.sv
// 4x4 matrix multiply C = A x B on a tiled array_size^2 output-stationary systolic MAC array,
// operating on a 48-word host-visible buffer (A, B, C).
module tpu_v1_pe #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] acc
);
    always_ff @(posedge clk) begin
        if (rst || clr) acc <= '0;
        else if (en)    acc <= acc + a * b;
    end
endmodule

module tpu_v1 #(
    parameter int datawith   = 16,
    parameter int array_size = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    tpu_if.slave   bus
);
    localparam int N  = 4;
    localparam int S  = array_size;
    localparam int T  = N / S;
    localparam int CL = N + 2 * S - 2;
    localparam int DW = datawith;

    typedef enum logic [2:0] {IDLE, CLEAR, COMPUTE, WB, DONE} state_t;

    state_t        state;
    logic [4:0]    cnt;
    logic [1:0]    ti, tj;
    logic          start_q;
    logic [DW-1:0] mem [48];

    logic [S-1:0][DW-1:0]        inj_a, inj_b;
    logic [S-1:0][S-1:0][DW-1:0] a_pipe, b_pipe, acc;
    logic [DW-1:0]               wb_data;
    logic [5:0]                  wb_addr;
    logic [4:0]                  phase;

    // Stage-0 pipe registers are loaded one phase ahead (starting in CLEAR), so
    // PE(i,j) sees k = cnt-i-j during COMPUTE and the window fits N+2S-2 cycles.
    always_comb begin
        inj_a   = '0;
        inj_b   = '0;
        wb_data = '0;
        wb_addr = '0;
        phase   = (state == CLEAR) ? 5'd0 : cnt + 5'd1;
        for (int i = 0; i < S; i++)
            for (int k = 0; k < N; k++)
                if ((state == CLEAR || state == COMPUTE) && phase == 5'(i + k)) begin
                    inj_a[i] = mem[6'(4 * (int'(ti) * S + i) + k)];
                    inj_b[i] = mem[6'(16 + 4 * k + int'(tj) * S + i)];
                end
        for (int i = 0; i < S; i++)
            for (int j = 0; j < S; j++)
                if (cnt == 5'(i * S + j)) begin
                    wb_data = acc[i][j];
                    wb_addr = 6'(32 + 4 * (int'(ti) * S + i) + int'(tj) * S + j);
                end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            a_pipe <= '0;
            b_pipe <= '0;
        end else if (state == CLEAR || state == COMPUTE) begin
            for (int i = 0; i < S; i++) begin
                a_pipe[i][0] <= inj_a[i];
                b_pipe[0][i] <= inj_b[i];
                for (int j = 1; j < S; j++) begin
                    a_pipe[i][j] <= (state == CLEAR) ? '0 : a_pipe[i][j-1];
                    b_pipe[j][i] <= (state == CLEAR) ? '0 : b_pipe[j-1][i];
                end
            end
        end
    end

    for (genvar gi = 0; gi < S; gi++) begin : g_row
        for (genvar gj = 0; gj < S; gj++) begin : g_col
            tpu_v1_pe #(.DW(DW)) u_pe (
                .clk (clk),
                .rst (rst_n),
                .clr (state == CLEAR),
                .en  (state == COMPUTE),
                .a   (a_pipe[gi][gj]),
                .b   (b_pipe[gi][gj]),
                .acc (acc[gi][gj])
            );
        end
    end

    // Buffer survives reset; host writes only land while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if (state == IDLE && bus.write_en && bus.write_addr < 10'd48)
                mem[bus.write_addr[5:0]] <= bus.data_in;
            else if (state == WB)
                mem[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n)
            bus.data_out <= '0;
        else if (!bus.write_en)
            bus.data_out <= (bus.write_addr < 10'd48) ? mem[bus.write_addr[5:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            ti           <= '0;
            tj           <= '0;
            start_q      <= 1'b0;
            bus.tpu_done <= 1'b0;
        end else begin
            start_q <= bus.tpu_start;
            case (state)
                IDLE: if (bus.tpu_start && !start_q) begin
                    state <= CLEAR;
                    ti    <= '0;
                    tj    <= '0;
                end
                CLEAR: begin
                    bus.tpu_done <= 1'b0;
                    cnt          <= '0;
                    state        <= COMPUTE;
                end
                COMPUTE: if (cnt == 5'(CL - 1)) begin
                    cnt   <= '0;
                    state <= WB;
                end else cnt <= cnt + 5'd1;
                WB: if (cnt == 5'(S * S - 1)) begin
                    cnt <= '0;
                    if (tj == 2'(T - 1)) begin
                        tj <= '0;
                        if (ti == 2'(T - 1)) state <= DONE;
                        else begin
                            ti    <= ti + 2'd1;
                            state <= CLEAR;
                        end
                    end else begin
                        tj    <= tj + 2'd1;
                        state <= CLEAR;
                    end
                end else cnt <= cnt + 5'd1;
                DONE: begin
                    bus.tpu_done <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tpu_v1.sv
// Self-checking bench for tpu_v1: constant table, random matrices vs a plain matrix-product model,
// and hand-written sequences for busy writes, held start and mid-run reset.
module tb_tpu_v1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tpu_if #(.DW(16)) bus ();
    tpu_v1 #(.datawith(16), .array_size(2)) dut (.clk(clk), .rst_n(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    logic [15:0] ma [16];
    logic [15:0] mb [16];

    typedef struct {
        logic [15:0] av;
        logic [15:0] bv;
        logic [15:0] ec;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [15:0] d);
        bus.write_addr = 10'(addr);
        bus.data_in    = d;
        bus.write_en   = 1'b1;
        tick();
        bus.write_en   = 1'b0;
    endtask

    task automatic rd(input int addr, output logic [15:0] d);
        bus.write_addr = 10'(addr);
        bus.write_en   = 1'b0;
        tick();
        d = bus.data_out;
    endtask

    task automatic load();
        for (int i = 0; i < 16; i++) wr(i, ma[i]);
        for (int i = 0; i < 16; i++) wr(16 + i, mb[i]);
    endtask

    task automatic wait_done(input string nm, input int n0);
        int n;
        n = n0;
        while (!bus.tpu_done && n < 200) begin
            tick();
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'd45);
    endtask

    task automatic run(input string nm);
        bus.tpu_start = 1'b1;
        tick();
        bus.tpu_start = 1'b0;
        tick();
        chk({nm, " done cleared"}, 32'(bus.tpu_done), 32'd0);
        wait_done(nm, 1);
    endtask

    task automatic check_c(input string nm);
        logic [31:0] s;
        logic [15:0] d;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++) begin
                s = '0;
                for (int k = 0; k < 4; k++) s += 32'(ma[4*r+k]) * 32'(mb[4*k+j]);
                rd(32 + 4 * r + j, d);
                chk($sformatf("%s C[%0d][%0d]", nm, r, j), 32'(d), 32'(s[15:0]));
            end
    endtask

    logic [15:0] d;

    initial begin
        bus.tpu_start  = 1'b0;
        bus.write_addr = '0;
        bus.data_size  = '0;
        bus.data_in    = '0;
        bus.write_en   = 1'b0;
        tbl[0] = '{16'h0002, 16'h0003, 16'h0018};
        tbl[1] = '{16'h0100, 16'h0100, 16'h0000};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 16'h0004};
        tbl[3] = '{16'h0001, 16'h0001, 16'h0004};
        tbl[4] = '{16'h7FFF, 16'h0002, 16'hFFF8};

        repeat (3) tick();
        rst = 1'b0;
        chk("reset data_out", 32'(bus.data_out), 32'd0);
        chk("reset tpu_done", 32'(bus.tpu_done), 32'd0);

        wr(50, 16'hBEEF);
        rd(50, d);
        chk("read addr 50", 32'(d), 32'd0);
        wr(5, 16'h1234);
        rd(5, d);
        chk("read addr 5", 32'(d), 32'h1234);
        wr(50, 16'h5555);
        chk("hold during write", 32'(bus.data_out), 32'h1234);

        for (int i = 0; i < 16; i++) begin
            ma[i] = 16'(i + 1);
            mb[i] = (i % 5 == 0) ? 16'd1 : 16'd0;
        end
        load();
        run("identity");
        for (int i = 0; i < 16; i++) begin
            rd(32 + i, d);
            chk($sformatf("identity C%0d", i), 32'(d), 32'(i + 1));
        end
        run("rerun");
        check_c("rerun");

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 16; i++) begin
                ma[i] = tbl[t].av;
                mb[i] = tbl[t].bv;
            end
            load();
            run($sformatf("tbl%0d", t));
            for (int i = 0; i < 16; i++) begin
                rd(32 + i, d);
                chk($sformatf("tbl%0d C%0d", t, i), 32'(d), 32'(tbl[t].ec));
            end
        end

        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 16; i++) begin
                ma[i] = (t == 2) ? 16'($urandom_range(0, 15)) : 16'($urandom);
                mb[i] = (t == 2) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            end
            load();
            run($sformatf("rand%0d", t));
            check_c($sformatf("rand%0d", t));
        end

        // Write while busy must be dropped.
        bus.tpu_start = 1'b1;
        tick();
        bus.tpu_start = 1'b0;
        wr(0, 16'hDEAD);
        wait_done("busy", 1);
        rd(0, d);
        chk("busy write ignored", 32'(d), 32'(ma[0]));
        check_c("busy");

        // Start held high gives exactly one run.
        bus.tpu_start = 1'b1;
        tick();
        tick();
        wait_done("held", 1);
        repeat (60) tick();
        chk("held single run", 32'(bus.tpu_done), 32'd1);
        check_c("held");
        bus.tpu_start = 1'b0;
        tick();

        // Reset in the middle of COMPUTE.
        ma[1] = 16'h5A5A;
        load();
        rd(1, d);
        chk("pre-reset read", 32'(d), 32'h5A5A);
        bus.tpu_start = 1'b1;
        tick();
        bus.tpu_start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midreset tpu_done", 32'(bus.tpu_done), 32'd0);
        chk("midreset data_out", 32'(bus.data_out), 32'd0);
        run("after reset");
        check_c("after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
